// File: rtl/fruit_pkg.sv
// Shared definitions for the fruit spawner stages: coordinate/colour widths,
// the dropper state type and the spawn-value helpers.
package fruit_pkg;

  localparam int COORD_W  = 7;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b111;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    SPAWN = 2'd1,
    FALL  = 2'd2
  } state_t;

  // Raw 7-bit values only overshoot by less than 64, and the column count is at least 64.
  // So a single conditional subtraction always lands inside the legal range.
  function automatic logic [COORD_W-1:0] wrap_column(input logic [COORD_W-1:0] raw,
                                                     input logic [COORD_W-1:0] limit);
    logic [COORD_W-1:0] col;
    col = raw;
    if (raw >= limit) col = raw - limit;
    return col;
  endfunction

  // Black means "no fruit", so a random black is turned into a visible colour.
  function automatic logic [COLOUR_W-1:0] spawn_colour(input logic [COLOUR_W-1:0] raw);
    logic [COLOUR_W-1:0] c;
    c = raw;
    if (raw == COLOUR_BLACK) c = 3'b000;
    return c;
  endfunction

endpackage

// File: rtl/fruit_dropper_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reloaded with SEED on reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic feedback;

  assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= {q[14:0], feedback};
  end

endmodule

// File: rtl/fruit_dropper.sv
// Spawns one falling fruit at a time at a pseudo-random column and colour, steps it
// down every FALL_DIV frames and reports one-cycle caught/missed pulses.
module fruit_dropper
  import fruit_pkg::*;
#(
  parameter int          X_LIMIT    = 120,
  parameter int          Y_LIMIT    = 120,
  parameter int          FALL_DIV   = 4,
  parameter int          GAP_FRAMES = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic                hit,
  output logic [COORD_W-1:0]  fruitx,
  output logic [COORD_W-1:0]  fruity,
  output logic [COLOUR_W-1:0] colour,
  output logic                caught,
  output logic [COLOUR_W-1:0] caught_colour,
  output logic                missed
);

  localparam int GAP_W = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
  localparam int DIV_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;

  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FALL_DIV - 1);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(X_LIMIT);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(Y_LIMIT - 1);

  logic [15:0]      lfsr;
  logic [5:0]       lfsr_unused;
  state_t           state;
  logic [GAP_W-1:0] gapcnt;
  logic [DIV_W-1:0] div;
  logic             frame_step;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign lfsr_unused = lfsr[15:10];
  assign frame_step  = frame_tick & enable;

  // A catch takes priority over a frame step, so a fruit hit on its bottom step is caught.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= GAP;
      fruitx        <= '0;
      fruity        <= '0;
      colour        <= COLOUR_BLACK;
      caught        <= 1'b0;
      missed        <= 1'b0;
      caught_colour <= '0;
      gapcnt        <= '0;
      div           <= '0;
    end else begin
      caught <= 1'b0;
      missed <= 1'b0;
      case (state)
        GAP: begin
          colour <= COLOUR_BLACK;
          if (frame_step) begin
            if (gapcnt == GAP_LAST) begin
              gapcnt <= '0;
              state  <= SPAWN;
            end else begin
              gapcnt <= gapcnt + 1'b1;
            end
          end
        end

        SPAWN: begin
          fruitx <= wrap_column(lfsr[6:0], X_MAX);
          fruity <= '0;
          colour <= spawn_colour(lfsr[9:7]);
          div    <= '0;
          state  <= FALL;
        end

        FALL: begin
          if (hit) begin
            caught        <= 1'b1;
            caught_colour <= colour;
            colour        <= COLOUR_BLACK;
            state         <= GAP;
          end else if (frame_step) begin
            if (div == DIV_LAST) begin
              div <= '0;
              if (fruity == Y_LAST) begin
                missed <= 1'b1;
                colour <= COLOUR_BLACK;
                state  <= GAP;
              end else begin
                fruity <= fruity + 1'b1;
              end
            end else begin
              div <= div + 1'b1;
            end
          end
        end

        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_dropper.sv
// Self-checking bench for fruit_dropper: a tick-counting model of the fruit's life
// checked every cycle, plus directed scenarios pinned with hand-computed values.
module tb_fruit_dropper;

  localparam int X_LIMIT    = 120;
  localparam int Y_LIMIT    = 120;
  localparam int FALL_DIV   = 4;
  localparam int GAP_FRAMES = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic       hit;
  logic [6:0] fruitx;
  logic [6:0] fruity;
  logic [2:0] colour;
  logic       caught;
  logic [2:0] caught_colour;
  logic       missed;

  int tests    = 0;
  int failures = 0;
  bit armed    = 1'b0;

  // Model state: the fruit's life is counted in enabled frame ticks, not rows.
  int m_phase;
  int m_gap_ticks;
  int m_fall_ticks;
  int m_x, m_y, m_col, m_ccol;
  int m_caught, m_missed;
  int m_lfsr;

  fruit_dropper #(
    .X_LIMIT    (X_LIMIT),
    .Y_LIMIT    (Y_LIMIT),
    .FALL_DIV   (FALL_DIV),
    .GAP_FRAMES (GAP_FRAMES),
    .SEED       (SEED)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .hit           (hit),
    .fruitx        (fruitx),
    .fruity        (fruity),
    .colour        (colour),
    .caught        (caught),
    .caught_colour (caught_colour),
    .missed        (missed)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 16'hFFFF;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic e, input logic h);
    frame_tick = t;
    enable     = e;
    hit        = h;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_gap_ticks = 0; m_fall_ticks = 0;
      m_x = 0; m_y = 0; m_col = 7; m_ccol = 0;
      m_caught = 0; m_missed = 0;
      m_lfsr = int'(SEED);
    end else begin
      m_caught = 0;
      m_missed = 0;
      if (m_phase == 0) begin
        if (frame_tick && enable) begin
          m_gap_ticks++;
          if (m_gap_ticks == GAP_FRAMES) begin
            m_gap_ticks = 0;
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        m_x = (m_lfsr & 127) % X_LIMIT;
        m_col = (m_lfsr >> 7) & 7;
        if (m_col == 7) m_col = 0;
        m_y = 0;
        m_fall_ticks = 0;
        m_phase = 2;
      end else begin
        if (hit) begin
          m_caught = 1;
          m_ccol = m_col;
          m_col = 7;
          m_phase = 0;
        end else if (frame_tick && enable) begin
          m_fall_ticks++;
          if (m_fall_ticks == Y_LIMIT * FALL_DIV) begin
            m_missed = 1;
            m_col = 7;
            m_phase = 0;
          end else begin
            m_y = m_fall_ticks / FALL_DIV;
          end
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("colour", int'(colour), m_col);
      checkOutput("caught", int'(caught), m_caught);
      checkOutput("missed", int'(missed), m_missed);
      checkOutput("caught_colour", int'(caught_colour), m_ccol);
      if (m_col != 7) begin
        checkOutput("fruitx", int'(fruitx), m_x);
        checkOutput("fruity", int'(fruity), m_y);
      end
    end
  end

  initial begin
    int fall_ticks;
    bit seen;
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; hit = 1'b0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    checkOutput("reset_colour", int'(colour), 7);
    checkOutput("reset_fruitx", int'(fruitx), 0);
    checkOutput("reset_fruity", int'(fruity), 0);
    checkOutput("reset_caught", int'(caught), 0);
    checkOutput("reset_missed", int'(missed), 0);

    // First spawn: the SPAWN cycle sees SEED advanced twice, 16'hB387.
    reset = 1'b0;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("spawn_latency_black", int'(colour), 7);
    applyStimulus(0, 1, 0);
    checkOutput("spawn1_fruitx", int'(fruitx), 7);
    checkOutput("spawn1_colour_remap", int'(colour), 0);
    checkOutput("spawn1_fruity", int'(fruity), 0);
    checkOutput("spawn1_x_legal", int'(fruitx < 7'd120), 1);

    // Fall with a pause mid-way; the divider must resume where it stopped.
    for (int i = 0; i < 42; i++) applyStimulus(1, 1, 0);
    checkOutput("fall_row_42_ticks", int'(fruity), 10);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0);
    checkOutput("pause_row", int'(fruity), 10);
    applyStimulus(1, 1, 0);
    checkOutput("resume_one_tick", int'(fruity), 10);
    applyStimulus(1, 1, 0);
    checkOutput("resume_two_ticks", int'(fruity), 11);
    fall_ticks = 44;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      applyStimulus(1, 1, 0);
      fall_ticks++;
      if (missed) seen = 1'b1;
    end
    checkOutput("miss_seen", int'(seen), 1);
    checkOutput("ticks_to_miss", fall_ticks, 480);
    checkOutput("miss_colour_black", int'(colour), 7);
    applyStimulus(0, 1, 0);
    checkOutput("miss_one_cycle", int'(missed), 0);

    // Catch a colour-2 fruit at row 5 with hit held for two cycles.
    applyStimulus(1, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (((lfsr_next(m_lfsr) >> 7) & 7) == 2) seen = 1'b1;
      else applyStimulus(0, 1, 0);
    end
    checkOutput("found_colour2", int'(seen), 1);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("spawn2_colour", int'(colour), 2);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0);
    checkOutput("row5", int'(fruity), 5);
    applyStimulus(0, 1, 1);
    checkOutput("catch_pulse", int'(caught), 1);
    checkOutput("catch_colour", int'(caught_colour), 2);
    checkOutput("catch_black", int'(colour), 7);
    applyStimulus(0, 1, 1);
    checkOutput("no_second_pulse", int'(caught), 0);
    applyStimulus(0, 1, 0);
    checkOutput("caught_colour_held", int'(caught_colour), 2);

    // Hit on the same edge as the bottom step: catch wins.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 479; i++) applyStimulus(1, 1, 0);
    checkOutput("bottom_row", int'(fruity), 119);
    applyStimulus(1, 1, 1);
    checkOutput("tie_caught", int'(caught), 1);
    checkOutput("tie_missed", int'(missed), 0);
    applyStimulus(0, 1, 0);

    // Column wrap: raw low bits 127 must land on column 7.
    applyStimulus(1, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if ((lfsr_next(m_lfsr) & 127) == 127) seen = 1'b1;
      else applyStimulus(0, 1, 0);
    end
    checkOutput("found_raw127", int'(seen), 1);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("wrap_fruitx", int'(fruitx), 7);

    // Reset mid-fall abandons the fruit without a pulse.
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0);
    reset = 1'b1;
    applyStimulus(0, 1, 0);
    checkOutput("midfall_reset_colour", int'(colour), 7);
    checkOutput("midfall_reset_fruity", int'(fruity), 0);
    checkOutput("midfall_reset_fruitx", int'(fruitx), 0);
    checkOutput("midfall_reset_caught", int'(caught), 0);
    checkOutput("midfall_reset_missed", int'(missed), 0);
    checkOutput("midfall_reset_ccol", int'(caught_colour), 0);
    reset = 1'b0;
    applyStimulus(0, 1, 0);

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fruit_dropper.md
# fruit_dropper

Upstream stage of the hit detector. Spawns one falling fruit at a time: a pseudo-random column and a pseudo-random colour. It moves the fruit down one row every `FALL_DIV` frames. It drives the fruit coordinates and colour that the hit detector compares against the character position. It consumes the detector's `hit` flag and emits one-cycle `caught`/`missed` pulses for the score stage.

## Interface
Parameters:
- `X_LIMIT`, default 120: number of legal columns, 0..X_LIMIT-1; legal range 64..127.
- `Y_LIMIT`, default 120: number of legal rows, 0..Y_LIMIT-1; legal range 2..127.
- `FALL_DIV`, default 4: frames per one-row step; ≥1.
- `GAP_FRAMES`, default 8: invisible frames between fruits; ≥1.
- `SEED`, default 16'hACE1: LFSR reset value; nonzero.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `enable` in 1: low freezes the fruit (pause).
- `hit` in 1: registered match flag from the hit detector.
- `fruitx` out 7: fruit column.
- `fruity` out 7: fruit row.
- `colour` out 3: fruit colour; 3'b111 = black/no fruit.
- `caught` out 1: one-cycle pulse, fruit caught.
- `caught_colour` out 3: colour of the caught fruit; valid while `caught` is high.
- `missed` out 1: one-cycle pulse, fruit reached the bottom uncaught.

## Operation
- States: GAP, SPAWN, FALL.
- Reset:
  - state = GAP; `fruitx` = 0, `fruity` = 0, `colour` = 3'b111.
  - `caught` = 0, `missed` = 0, `caught_colour` = 0.
  - gap counter = 0, divider = 0, LFSR = `SEED`.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every non-reset cycle, regardless of `enable`.
- GAP:
  - `colour` is held at 3'b111.
  - Each `frame_tick` with `enable` = 1 increments the gap counter.
  - When the counter reaches GAP_FRAMES-1 on a tick: clear the counter and go to SPAWN.
- SPAWN (exactly one cycle):
  - `fruitx` = lfsr[6:0], or lfsr[6:0] − X_LIMIT when lfsr[6:0] ≥ X_LIMIT. One subtraction is always sufficient.
  - `fruity` = 0.
  - `colour` = lfsr[9:7], remapped to 3'b000 when it equals 3'b111.
  - Divider = 0. Go to FALL.
- FALL:
  - `hit` = 1: pulse `caught`, set `caught_colour` = `colour`, set `colour` = 3'b111, go to GAP.
  - Otherwise, on `frame_tick` with `enable` = 1: increment the divider. When the divider equals FALL_DIV-1, clear it and step.
  - Step with `fruity` < Y_LIMIT-1: `fruity` += 1.
  - Step with `fruity` = Y_LIMIT-1: pulse `missed`, set `colour` = 3'b111, go to GAP.
- `hit` is ignored in GAP and SPAWN. This covers the stale detector output for one cycle after a catch.
- Simultaneous `hit` and bottom step: `hit` wins; `caught` is pulsed and `missed` is not.
- `enable` = 0: all frame-driven counters and the state are frozen. `hit` is still honoured in FALL.
- Reset mid-FALL: abandon the fruit with no pulse, and return to GAP with reset values.

## Timing
- All outputs are registered.
- A coordinate change appears one cycle after the edge that samples `frame_tick`.
- `caught` rises in the cycle after the edge sampling `hit` = 1 in FALL. It lasts exactly one cycle.
- `caught_colour` holds its value until the next catch.
- `missed` is one cycle, coincident with `colour` becoming 3'b111.
- Minimum fruit lifetime: SPAWN (1 cycle), then FALL.
- Latency from end of gap to a visible fruit: 2 cycles after the final gap tick.
- The hit detector's 1-cycle registration is tolerated:
  - The first FALL cycle sees `hit` computed from the SPAWN coordinates, which are legitimate.
  - The first GAP cycle sees `hit` from the FALL coordinates, which is ignored.

## Structure
- Shared package `fruit_pkg` contains:
  - `COORD_W` = 7, `COLOUR_W` = 3, `COLOUR_BLACK` = 3'b111.
  - The state enum (GAP, SPAWN, FALL).
- Sub-module `lfsr16`:
  - Ports: `clk`, `reset`, `SEED` parameter, 16-bit `q`.
  - Reusable by later spawners.

## Test plan
- Reset (any state), SEED = 16'hACE1 → `colour` = 7, `fruitx` = 0, `fruity` = 0, `caught` = `missed` = 0, state GAP.
- GAP_FRAMES = 2, FALL_DIV = 1, `hit` = 0 → SPAWN after the 2nd tick.
  - `fruitx` < 120, `colour` ≠ 7, `fruity` = 0.
  - Then `fruity` increments once per tick.
  - The tick at `fruity` = 119 gives `missed` = 1 for one cycle and `colour` = 7.
- FALL, `fruity` = 5, `colour` = 3'b010, assert `hit` for 2 cycles → one `caught` pulse, `caught_colour` = 3'b010, next `colour` = 7, no second pulse.
- `fruity` = 119 with `hit` = 1 on the same edge as the stepping tick → `caught` = 1, `missed` = 0.
- FALL_DIV = 4, `enable` = 0 for 10 ticks mid-fall → `fruity` and divider unchanged. Resuming needs exactly the remaining ticks to step.
- Force the LFSR low bits to 127 with X_LIMIT = 120 → `fruitx` = 7. Force lfsr[9:7] = 3'b111 → `colour` = 3'b000.
